// File: rtl/keypad_scan_ctrl_if.sv
// CPU-side keypad register interface: posted key code with valid/ack
// handshake, plus debounced held status and sticky overrun flag.
interface keypad_scan_ctrl_if;
  logic [5:0] Key_Code;
  logic       Key_Valid;
  logic       Key_Ack;
  logic       Key_Held;
  logic       Key_Overrun;

  // Scan controller side: produces events, consumes the acknowledge.
  modport master (
    output Key_Code,
    output Key_Valid,
    output Key_Held,
    output Key_Overrun,
    input  Key_Ack
  );

  // Consumer side: reads events, returns the acknowledge pulse.
  modport slave (
    input  Key_Code,
    input  Key_Valid,
    input  Key_Held,
    input  Key_Overrun,
    output Key_Ack
  );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// Keypad scan sequencer: strobes one column at a time, samples rows after a
// settle delay, debounces the first-hit key code across whole scan frames and
// posts one event per newly stable key through a valid/ack register.
module keypad_scan_ctrl #(
  parameter int NUM_COLS       = 4,
  parameter int NUM_ROWS       = 4,
  parameter int SETTLE_CYCLES  = 16,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Scan_Enable,
  input  logic [NUM_ROWS-1:0] Keyb_Row_I,
  output logic [NUM_COLS-1:0] Keyb_Col_O,
  keypad_scan_ctrl_if.master  key_if
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, EVAL} state_t;

  localparam logic [2:0]  LAST_COL    = 3'(NUM_COLS - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] DB_MAX      = 16'(DEBOUNCE_SCANS);

  state_t      state_q, state_d;
  logic [2:0]  col_q, col_d;
  logic [15:0] settle_q, settle_d;
  logic [15:0] match_q, match_d;
  logic [5:0]  cand_q, cand_d;     // first hit of the frame in progress
  logic [5:0]  prev_q, prev_d;     // candidate of the previous frame
  logic [5:0]  stable_q, stable_d; // debounced key code
  logic [5:0]  code_q, code_d;
  logic        valid_q, valid_d;
  logic        ovr_q, ovr_d;

  logic [2:0]  row_idx;
  logic [5:0]  hit_code;
  logic [15:0] match_next;
  logic        post;
  logic        ack_ok;

  // Key code of the lowest active row on the strobed column (decoder mapping).
  always_comb begin
    row_idx = '0;
    for (int r = NUM_ROWS - 1; r >= 0; r--) begin
      if (Keyb_Row_I[r]) row_idx = 3'(r);
    end
    hit_code = {1'b0, col_q, 2'b00} + {3'b000, row_idx} + 6'd1;
  end

  // Scan sequencing, frame debounce and event posting.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can hold a value and infer a latch.
    state_d    = state_q;
    col_d      = col_q;
    settle_d   = settle_q;
    match_d    = match_q;
    cand_d     = cand_q;
    prev_d     = prev_q;
    stable_d   = stable_q;
    code_d     = code_q;
    valid_d    = valid_q;
    ovr_d      = ovr_q;
    Keyb_Col_O = '0;
    match_next = '0;
    post       = 1'b0;

    // An acknowledge only counts against a pending event.
    ack_ok = key_if.Key_Ack && valid_q;
    if (ack_ok) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (Scan_Enable) begin
          state_d  = DRIVE;
          col_d    = '0;
          settle_d = '0;
        end
      end
      DRIVE: begin
        Keyb_Col_O = NUM_COLS'(1) << col_q;
        if (settle_q == SETTLE_LAST) state_d = SAMPLE;
        else                         settle_d = settle_q + 16'd1;
      end
      SAMPLE: begin
        Keyb_Col_O = NUM_COLS'(1) << col_q;
        // Scan order is column-major, so the first recorded hit wins.
        if ((cand_q == 6'd0) && (|Keyb_Row_I)) cand_d = hit_code;
        settle_d = '0;
        if (col_q == LAST_COL) begin
          state_d = EVAL;
        end else begin
          col_d   = col_q + 3'd1;
          state_d = DRIVE;
        end
      end
      EVAL: begin
        if (cand_q == prev_q) match_next = (match_q == DB_MAX) ? DB_MAX : match_q + 16'd1;
        else                  match_next = 16'd1;
        match_d = match_next;
        prev_d  = cand_q;
        cand_d  = '0;
        if ((match_next == DB_MAX) && (cand_q != stable_q)) begin
          stable_d = cand_q;
          post     = (cand_q != 6'd0);
        end
        // A new event overrides a same-cycle ack; otherwise a pending event blocks it.
        if (post) begin
          if (!valid_q || ack_ok) begin
            code_d  = cand_q;
            valid_d = 1'b1;
            ovr_d   = 1'b0;
          end else begin
            ovr_d = 1'b1;
          end
        end
        col_d    = '0;
        settle_d = '0;
        state_d  = Scan_Enable ? DRIVE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (Reset) begin
      // NOTE: all control state is reset, so a mid-frame reset discards the partial frame.
      state_q  <= IDLE;
      col_q    <= '0;
      settle_q <= '0;
      match_q  <= '0;
      cand_q   <= '0;
      prev_q   <= '0;
      stable_q <= '0;
      code_q   <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      settle_q <= settle_d;
      match_q  <= match_d;
      cand_q   <= cand_d;
      prev_q   <= prev_d;
      stable_q <= stable_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
    end
  end

  assign key_if.Key_Code    = code_q;
  assign key_if.Key_Valid   = valid_q;
  assign key_if.Key_Overrun = ovr_q;
  assign key_if.Key_Held    = (stable_q != 6'd0);

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a 4x4 key-matrix model answers the column
// strobes; a frame-level model (history queue of frame candidates) predicts
// the register outputs after every EVAL.
module tb_keypad_scan_ctrl;

  localparam int DB          = 4;
  localparam int FRAME_LEN   = 69;
  localparam int SETTLE      = 16;
  localparam logic [15:0] K1  = 16'h0001; // col0,row0 -> 1
  localparam logic [15:0] K10 = 16'h0200; // col2,row1 -> 10
  localparam logic [15:0] K13 = 16'h1000; // col3,row0 -> 13
  localparam logic [15:0] KP  = 16'h1080; // col1,row3 + col3,row0 -> 8

  logic        Clock;
  logic        Reset;
  logic        Scan_Enable;
  logic [3:0]  Keyb_Row_I;
  logic [3:0]  Keyb_Col_O;
  logic [15:0] key_mask;   // bit c*4+r = key at column c, row r pressed

  keypad_scan_ctrl_if kp ();

  keypad_scan_ctrl #(
    .NUM_COLS(4), .NUM_ROWS(4), .SETTLE_CYCLES(SETTLE), .DEBOUNCE_SCANS(DB)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Scan_Enable(Scan_Enable),
    .Keyb_Row_I (Keyb_Row_I),
    .Keyb_Col_O (Keyb_Col_O),
    .key_if     (kp)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Physical key matrix: a pressed key connects its column strobe to its row.
  always_comb begin
    Keyb_Row_I = '0;
    for (int c = 0; c < 4; c++) begin
      if (Keyb_Col_O[c]) Keyb_Row_I = Keyb_Row_I | key_mask[c*4 +: 4];
    end
  end

  int n_cmp;
  int n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int code, input bit valid, input bit held, input bit ovr);
    check({tag, " code"},    32'(kp.Key_Code),    32'(code));
    check({tag, " valid"},   32'(kp.Key_Valid),   32'(valid));
    check({tag, " held"},    32'(kp.Key_Held),    32'(held));
    check({tag, " overrun"}, 32'(kp.Key_Overrun), 32'(ovr));
  endtask

  // ---------------- frame-level reference model ----------------
  int m_hist[$];
  int m_stable, m_code;
  bit m_valid, m_ovr;

  function automatic int cand_of(input logic [15:0] m);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (m[c*4 + r]) return c*4 + r + 1;
    return 0;
  endfunction

  function automatic void model_clear();
    m_hist.delete();
    m_stable = 0; m_code = 0; m_valid = 0; m_ovr = 0;
  endfunction

  function automatic void model_ack();
    if (m_valid) begin m_valid = 0; m_ovr = 0; end
  endfunction

  // A key becomes stable once the last DB frames all saw the same candidate.
  function automatic void model_frame(input int cand, input bit ack);
    bit all_eq, post;
    m_hist.push_back(cand);
    if (m_hist.size() > DB) void'(m_hist.pop_front());
    all_eq = (m_hist.size() == DB);
    foreach (m_hist[i]) if (m_hist[i] != cand) all_eq = 0;
    post = 0;
    if (all_eq && cand != m_stable) begin
      m_stable = cand;
      post = (cand != 0);
    end
    if (post && (!m_valid || ack)) begin
      m_code = cand; m_valid = 1; m_ovr = 0;
    end else begin
      if (post) m_ovr = 1;
      if (ack) model_ack();
    end
  endfunction

  task automatic check_model(input string tag);
    check_outs(tag, m_code, m_valid, m_stable != 0, m_ovr);
  endtask

  // ---------------- stimulus tasks ----------------
  // Synchronous reset; leaves the bench in the first DRIVE cycle of frame 1.
  task automatic do_reset(input string tag);
    Reset = 1'b1;
    kp.Key_Ack = 1'b0;
    @(posedge Clock); #1;
    Reset = 1'b0;
    model_clear();
    check({tag, " col"}, 32'(Keyb_Col_O), 32'd0);
    check_outs(tag, 0, 0, 0, 0);
    @(posedge Clock); #1;
  endtask

  // One full frame from its first DRIVE cycle; strobe pattern checked per cycle.
  task automatic run_frame(input logic [15:0] mask, input bit ack_mid, input bit ack_eval, input bit drop_en);
    int bad;
    logic [3:0] exp_col;
    bad = 0;
    key_mask = mask;
    for (int j = 0; j < FRAME_LEN; j++) begin
      exp_col = (j < FRAME_LEN - 1) ? 4'(1 << (j / (SETTLE + 1))) : 4'd0;
      if (Keyb_Col_O !== exp_col) bad++;
      kp.Key_Ack = (ack_mid && j == 30) || (ack_eval && j == FRAME_LEN - 1);
      if (drop_en && j == 20) Scan_Enable = 1'b0;
      @(posedge Clock); #1;
    end
    kp.Key_Ack = 1'b0;
    check("col_seq bad cycles", 32'(bad), 32'd0);
    if (ack_mid) model_ack();
    model_frame(cand_of(mask), ack_eval);
  endtask

  typedef struct {
    bit          rst;
    logic [15:0] mask;
    bit          ack_mid;
    bit          ack_eval;
    int          code;
    bit          valid;
    bit          held;
    bit          ovr;
  } vec_t;

  vec_t tbl[38];

  function automatic vec_t v(input bit rst, input logic [15:0] m, input bit am, input bit ae,
                             input int code, input bit va, input bit he, input bit ov);
    vec_t r;
    r.rst = rst; r.mask = m; r.ack_mid = am; r.ack_eval = ae;
    r.code = code; r.valid = va; r.held = he; r.ovr = ov;
    return r;
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [15:0] cur;
    int bad;
    n_cmp = 0; n_fail = 0;
    Reset = 1'b1; Scan_Enable = 1'b1; key_mask = '0; kp.Key_Ack = 1'b0;

    // Idle frames, first press (valid at cycle 277), ack, release,
    // bounce, priority, overrun, ack-wins-with-new-event.
    tbl[0]  = v(1, 16'h0, 0, 0,  0, 0, 0, 0);
    tbl[1]  = v(0, 16'h0, 0, 0,  0, 0, 0, 0);
    tbl[2]  = v(0, 16'h0, 0, 0,  0, 0, 0, 0);
    tbl[3]  = v(1, K10,   0, 0,  0, 0, 0, 0);
    tbl[4]  = v(0, K10,   0, 0,  0, 0, 0, 0);
    tbl[5]  = v(0, K10,   0, 0,  0, 0, 0, 0);
    tbl[6]  = v(0, K10,   0, 0, 10, 1, 1, 0);
    tbl[7]  = v(0, K10,   1, 0, 10, 0, 1, 0);
    tbl[8]  = v(0, 16'h0, 0, 0, 10, 0, 1, 0);
    tbl[9]  = v(0, 16'h0, 0, 0, 10, 0, 1, 0);
    tbl[10] = v(0, 16'h0, 0, 0, 10, 0, 1, 0);
    tbl[11] = v(0, 16'h0, 0, 0, 10, 0, 0, 0);
    tbl[12] = v(0, K1,    0, 0, 10, 0, 0, 0);
    tbl[13] = v(0, K1,    0, 0, 10, 0, 0, 0);
    tbl[14] = v(0, 16'h0, 0, 0, 10, 0, 0, 0);
    tbl[15] = v(0, K1,    0, 0, 10, 0, 0, 0);
    tbl[16] = v(0, K1,    0, 0, 10, 0, 0, 0);
    tbl[17] = v(0, K1,    0, 0, 10, 0, 0, 0);
    tbl[18] = v(0, K1,    0, 0,  1, 1, 1, 0);
    tbl[19] = v(0, K1,    1, 0,  1, 0, 1, 0);
    tbl[20] = v(0, KP,    0, 0,  1, 0, 1, 0);
    tbl[21] = v(0, KP,    0, 0,  1, 0, 1, 0);
    tbl[22] = v(0, KP,    0, 0,  1, 0, 1, 0);
    tbl[23] = v(0, KP,    0, 0,  8, 1, 1, 0);
    tbl[24] = v(0, K13,   0, 0,  8, 1, 1, 0);
    tbl[25] = v(0, K13,   0, 0,  8, 1, 1, 0);
    tbl[26] = v(0, K13,   0, 0,  8, 1, 1, 0);
    tbl[27] = v(0, K13,   0, 0,  8, 1, 1, 1);
    tbl[28] = v(0, K13,   1, 0,  8, 0, 1, 0);
    tbl[29] = v(0, K1,    0, 0,  8, 0, 1, 0);
    tbl[30] = v(0, K1,    0, 0,  8, 0, 1, 0);
    tbl[31] = v(0, K1,    0, 0,  8, 0, 1, 0);
    tbl[32] = v(0, K1,    0, 0,  1, 1, 1, 0);
    tbl[33] = v(0, K10,   0, 0,  1, 1, 1, 0);
    tbl[34] = v(0, K10,   0, 0,  1, 1, 1, 0);
    tbl[35] = v(0, K10,   0, 0,  1, 1, 1, 0);
    tbl[36] = v(0, K10,   0, 1, 10, 1, 1, 0);
    tbl[37] = v(0, K10,   1, 0, 10, 0, 1, 0);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset($sformatf("reset@vec%0d", i));
      run_frame(tbl[i].mask, tbl[i].ack_mid, tbl[i].ack_eval, 1'b0);
      check_outs($sformatf("vec%0d", i), tbl[i].code, tbl[i].valid, tbl[i].held, tbl[i].ovr);
    end

    // Reset in the middle of col2 DRIVE of the 3rd frame of a press.
    do_reset("pre_midreset");
    run_frame(K10, 0, 0, 0); check_outs("midrst f1", 0, 0, 0, 0);
    run_frame(K10, 0, 0, 0); check_outs("midrst f2", 0, 0, 0, 0);
    key_mask = K10;
    for (int j = 0; j < 40; j++) begin @(posedge Clock); #1; end
    check("midrst col2 strobe", 32'(Keyb_Col_O), 32'd4);
    do_reset("midrst");
    for (int f = 1; f <= 3; f++) begin
      run_frame(K10, 0, 0, 0);
      check_outs($sformatf("after_rst f%0d", f), 0, 0, 0, 0);
    end
    run_frame(K10, 0, 0, 0);
    check_outs("after_rst f4", 10, 1, 1, 0);

    // Scan_Enable dropped mid-frame: frame completes, then idles; restart at col0.
    run_frame(16'h0, 1, 0, 1);
    check_model("drop frame");
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (Keyb_Col_O !== 4'd0) bad++;
      @(posedge Clock); #1;
    end
    check("idle col bad cycles", 32'(bad), 32'd0);
    Scan_Enable = 1'b1;
    @(posedge Clock); #1;
    check("restart col0", 32'(Keyb_Col_O), 32'd1);
    run_frame(16'h0, 0, 0, 0);
    check_model("restart frame");

    // Randomised frames against the reference model.
    cur = '0;
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 9) < 3) begin
        case ($urandom_range(0, 2))
          0: cur = '0;
          1: cur = 16'(1) << $urandom_range(0, 15);
          default: cur = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
        endcase
      end
      run_frame(cur, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, 1'b0);
      check_model($sformatf("rand%0d", f));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
